// File: rtl/multi_in_reduce_pkg.sv
// Shared types and width helpers for the multi-input reduction unit.
// Widths are derived from WIDTH/WINDOW so that full-window counts never wrap.
package multi_in_reduce_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Bits needed to hold a popcount of an entire window (WIDTH*WINDOW ones).
  function automatic int pop_w(input int width, input int window);
    return $clog2(width * window + 1);
  endfunction

  // Bits needed to hold a sample count in the range 0..WINDOW.
  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

  // Bits needed to hold the popcount of a single sample.
  function automatic int vec_pop_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multi_in_reduce_reduce_vec.sv
// Combinational per-sample reduction: AND, OR, XOR and popcount of one vector.
module reduce_vec
  import multi_in_reduce_pkg::*;
#(
  parameter int WIDTH = 3,
  localparam int VPOP_W = vec_pop_w(WIDTH)
) (
  input  logic [WIDTH-1:0]  data_i,
  output logic              and_o,
  output logic              or_o,
  output logic              xor_o,
  output logic [VPOP_W-1:0] pop_o
);

  assign and_o = &data_i;
  assign or_o  = |data_i;
  assign xor_o = ^data_i;

  always_comb begin
    pop_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_o = pop_o + VPOP_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/multi_in_reduce.sv
// Windowed AND/OR/XOR/popcount reduction with a valid/ready output buffer.
// A window closes on the WINDOW-th sample or on flush; the result is held until taken.
module multi_in_reduce
  import multi_in_reduce_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int WINDOW = 4,
  localparam int POP_W  = pop_w(WIDTH, WINDOW),
  localparam int CNT_W  = cnt_w(WINDOW),
  localparam int VPOP_W = vec_pop_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_and,
  output logic             out_or,
  output logic             out_xor,
  output logic [POP_W-1:0] out_pop,
  output logic [CNT_W-1:0] out_samples
);

  state_e state_q, state_d;

  logic             acc_and_q, acc_and_d;
  logic             acc_or_q,  acc_or_d;
  logic             acc_xor_q, acc_xor_d;
  logic [POP_W-1:0] acc_pop_q, acc_pop_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic             out_valid_q, out_valid_d;
  logic             out_and_q,   out_and_d;
  logic             out_or_q,    out_or_d;
  logic             out_xor_q,   out_xor_d;
  logic [POP_W-1:0] out_pop_q,   out_pop_d;
  logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;

  logic              s_and, s_or, s_xor;
  logic [VPOP_W-1:0] s_pop;

  logic             accept;
  logic             close_win;
  logic             win_and, win_or, win_xor;
  logic [POP_W-1:0] win_pop;
  logic [CNT_W-1:0] win_cnt;

  reduce_vec #(
    .WIDTH (WIDTH)
  ) u_reduce_vec (
    .data_i (in_data),
    .and_o  (s_and),
    .or_o   (s_or),
    .xor_o  (s_xor),
    .pop_o  (s_pop)
  );

  // in_ready depends only on registered state, never on in_valid/out_ready.
  assign in_ready = (state_q == ACCUM);
  assign accept   = in_valid && in_ready;

  // Window contents including the current sample when it is accepted.
  assign win_and = accept ? (acc_and_q & s_and) : acc_and_q;
  assign win_or  = accept ? (acc_or_q | s_or)   : acc_or_q;
  assign win_xor = accept ? (acc_xor_q ^ s_xor) : acc_xor_q;
  assign win_pop = accept ? (acc_pop_q + POP_W'(s_pop)) : acc_pop_q;
  assign win_cnt = accept ? (cnt_q + CNT_W'(1)) : cnt_q;

  always_comb begin
    state_d     = state_q;
    acc_and_d   = acc_and_q;
    acc_or_d    = acc_or_q;
    acc_xor_d   = acc_xor_q;
    acc_pop_d   = acc_pop_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_and_d   = out_and_q;
    out_or_d    = out_or_q;
    out_xor_d   = out_xor_q;
    out_pop_d   = out_pop_q;
    out_cnt_d   = out_cnt_q;
    close_win   = 1'b0;

    unique case (state_q)
      ACCUM: begin
        close_win = (accept && (win_cnt == CNT_W'(WINDOW)))
                 || (flush && (accept || (cnt_q != '0)));
        acc_and_d = win_and;
        acc_or_d  = win_or;
        acc_xor_d = win_xor;
        acc_pop_d = win_pop;
        cnt_d     = win_cnt;
        if (close_win) begin
          out_valid_d = 1'b1;
          out_and_d   = win_and;
          out_or_d    = win_or;
          out_xor_d   = win_xor;
          out_pop_d   = win_pop;
          out_cnt_d   = win_cnt;
          acc_and_d   = 1'b1;
          acc_or_d    = 1'b0;
          acc_xor_d   = 1'b0;
          acc_pop_d   = '0;
          cnt_d       = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_and_q   <= 1'b1;
      acc_or_q    <= 1'b0;
      acc_xor_q   <= 1'b0;
      acc_pop_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_and_q   <= 1'b0;
      out_or_q    <= 1'b0;
      out_xor_q   <= 1'b0;
      out_pop_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_and_q   <= acc_and_d;
      acc_or_q    <= acc_or_d;
      acc_xor_q   <= acc_xor_d;
      acc_pop_q   <= acc_pop_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_and_q   <= out_and_d;
      out_or_q    <= out_or_d;
      out_xor_q   <= out_xor_d;
      out_pop_q   <= out_pop_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_and     = out_and_q;
  assign out_or      = out_or_q;
  assign out_xor     = out_xor_q;
  assign out_pop     = out_pop_q;
  assign out_samples = out_cnt_q;

endmodule

// File: tb/tb_multi_in_reduce.sv
// Directed and randomized checks of multi_in_reduce against a window-level model
// (small 3x4 instance plus an 8x16 instance for the wide popcount case).
module tb_multi_in_reduce;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, flush;
  logic [2:0] in_data;
  logic       out_valid, out_ready, out_and, out_or, out_xor;
  logic [3:0] out_pop;
  logic [2:0] out_samples;

  logic       w_in_valid, w_in_ready, w_flush;
  logic [7:0] w_in_data;
  logic       w_out_valid, w_out_ready, w_out_and, w_out_or, w_out_xor;
  logic [7:0] w_out_pop;
  logic [4:0] w_out_samples;

  int n_checks = 0;
  int n_err    = 0;
  int unsigned win[$];

  always #5 clk = ~clk;

  multi_in_reduce #(.WIDTH(3), .WINDOW(4)) u_dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .flush (flush),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_and (out_and), .out_or (out_or), .out_xor (out_xor),
    .out_pop (out_pop), .out_samples (out_samples)
  );

  multi_in_reduce #(.WIDTH(8), .WINDOW(16)) u_dut_w (
    .clk (clk), .rst (rst),
    .in_valid (w_in_valid), .in_ready (w_in_ready), .in_data (w_in_data), .flush (w_flush),
    .out_valid (w_out_valid), .out_ready (w_out_ready),
    .out_and (w_out_and), .out_or (w_out_or), .out_xor (w_out_xor),
    .out_pop (w_out_pop), .out_samples (w_out_samples)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window summary from total ones count: all-ones iff pop==3n, any iff pop>0, parity = pop mod 2.
  task automatic check_result(input string tag);
    int pop;
    int n;
    pop = 0;
    n   = win.size();
    foreach (win[i]) pop += $countones(win[i]);
    chk({tag, ".valid"},   32'(out_valid),   32'd1);
    chk({tag, ".and"},     32'(out_and),     32'(pop == 3 * n));
    chk({tag, ".or"},      32'(out_or),      32'(pop != 0));
    chk({tag, ".xor"},     32'(out_xor),     32'(pop % 2));
    chk({tag, ".pop"},     32'(out_pop),     32'(pop));
    chk({tag, ".samples"}, 32'(out_samples), 32'(n));
    chk({tag, ".in_ready"}, 32'(in_ready),   32'd0);
  endtask

  task automatic step(input string tag, input logic [2:0] d, input logic v, input logic fl,
                      output logic closed);
    chk({tag, ".rdy_before"}, 32'(in_ready), 32'd1);
    in_valid = v;
    in_data  = d;
    flush    = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    if (v) win.push_back(32'(d));
    closed = (v && win.size() == 4) || (fl && win.size() > 0);
    if (closed) check_result(tag);
    else chk({tag, ".no_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Stall for `stall` cycles with junk on the input side, then take the result.
  task automatic take(input string tag, input int stall);
    for (int i = 0; i < stall; i++) begin
      in_valid  = 1'b1;
      in_data   = 3'($urandom);
      flush     = 1'($urandom);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check_result({tag, ".stall"});
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".taken_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".taken_ready"}, 32'(in_ready),  32'd1);
    win.delete();
  endtask

  initial begin
    logic closed;
    int   iter;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_flush = 1'b0; w_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.ready", 32'(in_ready), 32'd1);
    chk("reset.and", 32'(out_and), 32'd0);
    chk("reset.pop", 32'(out_pop), 32'd0);
    chk("reset.samples", 32'(out_samples), 32'd0);
    rst = 1'b0;

    step("b2b", 3'b111, 1, 0, closed);
    step("b2b", 3'b110, 1, 0, closed);
    step("b2b", 3'b011, 1, 0, closed);
    step("b2b", 3'b111, 1, 0, closed);
    chk("b2b.pop10", 32'(out_pop), 32'd10);
    take("b2b", 0);

    step("stall", 3'b111, 1, 0, closed);
    step("stall", 3'b110, 1, 0, closed);
    step("stall", 3'b011, 1, 0, closed);
    step("stall", 3'b111, 1, 0, closed);
    take("stall", 5);

    step("flush", 3'b111, 1, 0, closed);
    step("flush", 3'b111, 1, 0, closed);
    step("flush", 3'b000, 0, 1, closed);
    chk("flush.pop6", 32'(out_pop), 32'd6);
    take("flush", 0);
    step("flush_empty", 3'b101, 0, 1, closed);

    step("flush_acc", 3'b010, 1, 0, closed);
    step("flush_acc", 3'b001, 1, 1, closed);
    chk("flush_acc.samples2", 32'(out_samples), 32'd2);
    take("flush_acc", 1);

    step("rst_mid", 3'b111, 1, 0, closed);
    step("rst_mid", 3'b101, 1, 0, closed);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    win.delete();
    chk("rst_mid.valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) step("zeros", 3'b000, 1, 0, closed);
    take("zeros", 0);

    for (int i = 0; i < 4; i++) step("rst_hold", 3'b110, 1, 0, closed);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    win.delete();
    chk("rst_hold.valid", 32'(out_valid), 32'd0);
    chk("rst_hold.and", 32'(out_and), 32'd0);
    chk("rst_hold.or", 32'(out_or), 32'd0);
    chk("rst_hold.xor", 32'(out_xor), 32'd0);
    chk("rst_hold.pop", 32'(out_pop), 32'd0);
    chk("rst_hold.samples", 32'(out_samples), 32'd0);
    chk("rst_hold.ready", 32'(in_ready), 32'd1);

    for (int w = 0; w < 30; w++) begin
      closed = 1'b0;
      iter   = 0;
      while (!closed && iter < 40) begin
        step("rand", 3'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 7) == 0), closed);
        iter++;
      end
      chk("rand.closed", 32'(closed), 32'd1);
      if (closed) take("rand", $urandom_range(0, 3));
    end

    for (int i = 0; i < 16; i++) begin
      w_in_valid = 1'b1;
      w_in_data  = 8'hFF;
      @(posedge clk);
      #1;
      if (i < 15) chk("wide.no_valid", 32'(w_out_valid), 32'd0);
    end
    w_in_valid = 1'b0;
    chk("wide.valid", 32'(w_out_valid), 32'd1);
    chk("wide.pop", 32'(w_out_pop), 32'(16 * 8));
    chk("wide.and", 32'(w_out_and), 32'd1);
    chk("wide.or", 32'(w_out_or), 32'd1);
    chk("wide.xor", 32'(w_out_xor), 32'd0);
    chk("wide.samples", 32'(w_out_samples), 32'd16);
    chk("wide.ready", 32'(w_in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
